nano_loader: RTL and testbench

Program loader that sits directly upstream of the NanoCPU memory port. After reset it holds the CPU in reset, accepts a framed program image over a valid/ready word stream, and writes it into the 256 x 16 memory. When the image checksum matches, it hands the memory port to the CPU and releases the CPU reset. A checksum mismatch leaves the CPU in reset and raises an error flag.

---
 rtl/nano_pkg.sv | 21 ++
 rtl/nano_mem_mux.sv | 26 ++
 rtl/nano_loader.sv | 114 +++++++++++
 tb/tb_nano_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Shared constants, header field positions and loader state encoding for the
// NanoCPU program loader.
package nano_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam int BASE_MSB = 15;
    localparam int BASE_LSB = 8;
    localparam int CNT_MSB  = 7;
    localparam int CNT_LSB  = 0;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/nano_mem_mux.sv
// Memory port selection: the loader's write register while loading, the CPU
// port once the image is verified.
module nano_mem_mux
    import nano_pkg::*;
(
    input  logic              cpu_sel,
    input  logic [ADDR_W-1:0] ldr_address,
    input  logic [DATA_W-1:0] ldr_dataW,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dataW,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_ce,
    output logic              mem_we
);

    // The loader only ever writes, so its chip enable is its write strobe.
    assign mem_address = cpu_sel ? cpu_address : ldr_address;
    assign mem_dataW   = cpu_sel ? cpu_dataW   : ldr_dataW;
    assign mem_ce      = cpu_sel ? cpu_ce      : ldr_we;
    assign mem_we      = cpu_sel ? cpu_we      : ldr_we;

endmodule

// File: rtl/nano_loader.sv
// Framed program loader: receives header/data/checksum over a valid/ready
// stream, writes the image into memory and releases the CPU on a good checksum.
module nano_loader
    import nano_pkg::*;
(
    input  logic              ck,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dataW,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    loader_state_t     state, state_nx;
    logic [ADDR_W-1:0] base, last_idx;
    logic [DATA_W-1:0] sum;
    logic              wr_pending;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              hs;

    assign hs   = s_valid && s_ready;
    assign busy = (state == HDR) || (state == DATA) || (state == CSUM);

    // NOTE: state_nx is assigned before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        if (reload) begin
            state_nx = HDR;
        end else begin
            case (state)
                HDR:     if (hs) state_nx = DATA;
                DATA:    if (hs && (words_loaded[ADDR_W-1:0] == last_idx)) state_nx = CSUM;
                CSUM:    if (hs) state_nx = (s_data == sum) ? DONE : ERR;
                default: state_nx = state;
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state        <= HDR;
            s_ready      <= 1'b0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            base         <= '0;
            last_idx     <= '0;
            sum          <= '0;
            words_loaded <= '0;
            wr_pending   <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            state      <= state_nx;
            s_ready    <= (state_nx == HDR) || (state_nx == DATA) || (state_nx == CSUM);
            cpu_rst    <= (state_nx != DONE);
            done       <= (state_nx == DONE);
            err        <= (state_nx == ERR);
            wr_pending <= 1'b0;
            if (reload) begin
                words_loaded <= '0;
            end else if (hs) begin
                case (state)
                    HDR: begin
                        base         <= s_data[BASE_MSB:BASE_LSB];
                        last_idx     <= s_data[CNT_MSB:CNT_LSB];
                        sum          <= '0;
                        words_loaded <= '0;
                    end
                    DATA: begin
                        wr_pending   <= 1'b1;
                        wr_addr      <= base + words_loaded[ADDR_W-1:0];
                        wr_data      <= s_data;
                        sum          <= sum + s_data;
                        words_loaded <= words_loaded + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // done is a registered decode of DONE, so the port select never follows CPU inputs.
    nano_mem_mux u_mem_mux (
        .cpu_sel     (done),
        .ldr_address (wr_addr),
        .ldr_dataW   (wr_data),
        .ldr_we      (wr_pending),
        .cpu_address (cpu_address),
        .cpu_dataW   (cpu_dataW),
        .cpu_ce      (cpu_ce),
        .cpu_we      (cpu_we),
        .mem_address (mem_address),
        .mem_dataW   (mem_dataW),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we)
    );

endmodule

// File: tb/tb_nano_loader.sv
// Bench for nano_loader: a behavioural memory records every write, and images
// are checked against addresses and checksums computed from the frame rules.
module tb_nano_loader;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        reload = 1'b0;
    logic        cpu_rst;
    logic [7:0]  cpu_address = '0;
    logic [15:0] cpu_dataW = '0;
    logic        cpu_ce = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  mem_address;
    logic [15:0] mem_dataW;
    logic        mem_ce;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [256];
    int          wcnt [256];
    int          wsnap [256];
    logic [15:0] data_q [$];

    always #5 ck = ~ck;

    nano_loader dut (
        .ck           (ck),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .reload       (reload),
        .cpu_rst      (cpu_rst),
        .cpu_address  (cpu_address),
        .cpu_dataW    (cpu_dataW),
        .cpu_ce       (cpu_ce),
        .cpu_we       (cpu_we),
        .mem_address  (mem_address),
        .mem_dataW    (mem_dataW),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always @(posedge ck) begin
        if (mem_ce && mem_we) begin
            mem[mem_address]  <= mem_dataW;
            wcnt[mem_address] <= wcnt[mem_address] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_sum();
        logic [15:0] s = '0;
        foreach (data_q[i]) s = s + data_q[i];
        return s;
    endfunction

    task automatic snapshot();
        for (int i = 0; i < 256; i++) wsnap[i] = wcnt[i];
    endtask

    task automatic send(input logic [15:0] w, input int gap);
        int t = 0;
        s_valid = 1'b0;
        repeat (gap) begin @(posedge ck); #1; end
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 50) begin @(posedge ck); #1; t++; end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: s_ready=%0b required 1 for word %h", s_ready, w);
        end
        @(posedge ck); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_data(input int max_gap);
        foreach (data_q[i]) send(data_q[i], int'($urandom_range(max_gap, 0)));
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge ck); #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({s_ready, cpu_rst, mem_we, mem_ce, mem_address, mem_dataW, busy, done, err, words_loaded}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000}) begin
            failures++;
            $display("FAIL reset_values: got %h required %h",
                     {s_ready, cpu_rst, mem_we, mem_ce, mem_address, mem_dataW, busy, done, err, words_loaded},
                     {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %b required 0", s_ready); end
        @(posedge ck); #1;
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge: got %b required 1", s_ready); end
    endtask

    task automatic test_basic();
        data_q = '{16'h8000, 16'h8110, 16'h9220};
        send(16'h1402, 0);
        send_data(0);
        checks++;
        if ({done, cpu_rst, words_loaded} !== {1'b0, 1'b1, 9'd3}) begin
            failures++;
            $display("FAIL basic_pre_csum: done/cpu_rst/words=%b/%b/%0d required 0/1/3", done, cpu_rst, words_loaded);
        end
        send(16'h9330, 0);
        checks++;
        if ({done, cpu_rst, err, s_ready, busy, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd3}) begin
            failures++;
            $display("FAIL basic_done: done/cpu_rst/err/ready/busy/words=%b/%b/%b/%b/%b/%0d required 1/0/0/0/0/3",
                     done, cpu_rst, err, s_ready, busy, words_loaded);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[8'h14 + i] !== data_q[i]) begin
                failures++;
                $display("FAIL basic_mem[%h]: got %h required %h", 8'h14 + i, mem[8'h14 + i], data_q[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cpu_address = 8'($urandom);
            cpu_dataW   = 16'($urandom);
            cpu_ce      = 1'($urandom);
            cpu_we      = 1'($urandom);
            #1;
            checks++;
            if ({mem_address, mem_dataW, mem_ce, mem_we} !== {cpu_address, cpu_dataW, cpu_ce, cpu_we}) begin
                failures++;
                $display("FAIL passthrough: got %h required %h",
                         {mem_address, mem_dataW, mem_ce, mem_we}, {cpu_address, cpu_dataW, cpu_ce, cpu_we});
            end
        end
        cpu_ce = 1'b0;
        cpu_we = 1'b0;
        @(posedge ck); #1;
    endtask

    task automatic test_reload_and_err();
        do_reload();
        checks++;
        if ({cpu_rst, busy, done, words_loaded, s_ready} !== {1'b1, 1'b1, 1'b0, 9'd0, 1'b1}) begin
            failures++;
            $display("FAIL reload_from_done: cpu_rst/busy/done/words/ready=%b/%b/%b/%0d/%b required 1/1/0/0/1",
                     cpu_rst, busy, done, words_loaded, s_ready);
        end
        data_q = '{16'h8000, 16'h8110, 16'h9220};
        send(16'h1402, 0);
        send_data(0);
        send(16'h0000, 0);
        checks++;
        if ({err, done, cpu_rst, s_ready} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL err_state: err/done/cpu_rst/ready=%b/%b/%b/%b required 1/0/1/0", err, done, cpu_rst, s_ready);
        end
        cpu_address = 8'h14;
        cpu_dataW   = 16'hDEAD;
        cpu_ce      = 1'b1;
        cpu_we      = 1'b1;
        s_valid     = 1'b1;
        s_data      = 16'h1234;
        #1;
        checks++;
        if ({mem_ce, mem_we} !== 2'b00) begin
            failures++;
            $display("FAIL err_blocks_cpu: mem_ce/mem_we=%b/%b required 0/0", mem_ce, mem_we);
        end
        @(posedge ck); #1;
        checks++;
        if (mem[8'h14] !== 16'h8000) begin
            failures++;
            $display("FAIL err_mem_untouched: got %h required 8000", mem[8'h14]);
        end
        cpu_ce  = 1'b0;
        cpu_we  = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic test_wrap();
        do_reload();
        data_q = '{16'($urandom), 16'($urandom), 16'($urandom)};
        send(16'hFE02, 0);
        send_data(0);
        send(ref_sum(), 0);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL wrap_done: got %b required 1", done); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a;
            a = 8'((254 + i) % 256);
            checks++;
            if (mem[a] !== data_q[i]) begin
                failures++;
                $display("FAIL wrap_mem[%h]: got %h required %h", a, mem[a], data_q[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        do_reload();
        data_q.delete();
        for (int i = 0; i < 256; i++) data_q.push_back(16'($urandom));
        snapshot();
        send(16'h00FF, 2);
        send_data(3);
        checks++;
        if (words_loaded !== 9'd256) begin
            failures++;
            $display("FAIL gaps_words: got %0d required 256", words_loaded);
        end
        send(ref_sum(), 2);
        checks++;
        if ({done, err} !== 2'b10) begin failures++; $display("FAIL gaps_done: done/err=%b/%b required 1/0", done, err); end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (mem[i] !== data_q[i] || wcnt[i] - wsnap[i] != 1) begin
                failures++;
                $display("FAIL gaps_mem[%0d]: got %h x%0d required %h x1", i, mem[i], wcnt[i] - wsnap[i], data_q[i]);
            end
        end
    endtask

    task automatic test_reload_mid_data();
        logic [15:0] d0, d1;
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        do_reload();
        snapshot();
        send(16'h4003, 0);
        send(d0, 0);
        s_valid = 1'b1;
        s_data  = d1;
        reload  = 1'b1;
        @(posedge ck); #1;
        reload  = 1'b0;
        s_valid = 1'b0;
        checks++;
        if ({words_loaded, busy, s_ready, done, mem_we} !== {9'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reload_mid_data: words/busy/ready/done/mem_we=%0d/%b/%b/%b/%b required 0/1/1/0/0",
                     words_loaded, busy, s_ready, done, mem_we);
        end
        @(posedge ck); #1;
        checks++;
        if (wcnt[8'h40] - wsnap[8'h40] != 1 || wcnt[8'h41] - wsnap[8'h41] != 0) begin
            failures++;
            $display("FAIL reload_discard: writes at 40/41=%0d/%0d required 1/0",
                     wcnt[8'h40] - wsnap[8'h40], wcnt[8'h41] - wsnap[8'h41]);
        end
        data_q = '{16'($urandom), 16'($urandom)};
        send(16'h6001, 0);
        send_data(1);
        send(ref_sum(), 0);
        checks++;
        if ({done, mem[8'h60], mem[8'h61]} !== {1'b1, data_q[0], data_q[1]}) begin
            failures++;
            $display("FAIL second_image: got %h required %h", {done, mem[8'h60], mem[8'h61]}, {1'b1, data_q[0], data_q[1]});
        end
    endtask

    task automatic test_rst_mid_data();
        do_reload();
        send(16'h8007, 0);
        send(16'($urandom), 0);
        send(16'($urandom), 0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_ready, cpu_rst, mem_we, mem_ce, mem_address, mem_dataW, busy, done, err, words_loaded}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000}) begin
            failures++;
            $display("FAIL rst_mid_data: got %h required %h",
                     {s_ready, cpu_rst, mem_we, mem_ce, mem_address, mem_dataW, busy, done, err, words_loaded},
                     {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'h000});
        end
        #3;
        rst = 1'b1;
        data_q.delete();
        for (int i = 0; i < 8; i++) data_q.push_back(16'($urandom));
        send(16'h8007, 0);
        send_data(1);
        send(ref_sum(), 0);
        checks++;
        if ({done, cpu_rst, words_loaded} !== {1'b1, 1'b0, 9'd8}) begin
            failures++;
            $display("FAIL rst_reload_done: done/cpu_rst/words=%b/%b/%0d required 1/0/8", done, cpu_rst, words_loaded);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[8'h80 + i] !== data_q[i]) begin
                failures++;
                $display("FAIL rst_reload_mem[%h]: got %h required %h", 8'h80 + i, mem[8'h80 + i], data_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload_and_err();
        test_wrap();
        test_random_gaps();
        test_reload_mid_data();
        test_rst_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
